multi_operand_loader: RTL

- Parametrised successor to the two-register operand entry path (request/confirm control unit plus left/right registers).
- Operator asserts request to arm. Each confirm press latches inputData into the next of NUM_CH operand registers.
- Adds per-channel valid flags, a done pulse, restart-on-request, and a selectable truncate/saturate narrowing mode.
- Feeds the downstream arithmetic stage through a flattened operand bus.

---
 rtl/loader_pkg.sv | 38 +++
 rtl/edge_rise.sv | 23 ++
 rtl/multi_operand_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for operand loaders: FSM state codes and the narrowing helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package loader_pkg;

    // Only the four codes below are reachable. Any other value falls back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_CAPT = 3'd2,
        ST_DONE = 3'd3
    } state_t;

    // Operands are handled at up to 32 bits here.
    // Callers zero-extend their input and cast the result back to their own width.
    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] keep_mask(input int data_w);
        keep_mask = (data_w >= MAX_W) ? '1 : ((32'd1 << data_w) - 32'd1);
    endfunction

    // True when any bit at or above data_w is set, so the value does not fit.
    function automatic logic clips(input logic [MAX_W-1:0] din, input int data_w);
        clips = (din & ~keep_mask(data_w)) != '0;
    endfunction

    // sat=0: keep the low data_w bits.
    // sat=1: clamp to the all-ones value when the input does not fit.
    function automatic logic [MAX_W-1:0] narrow(input logic [MAX_W-1:0] din,
                                                 input logic sat,
                                                 input int data_w);
        if (sat && clips(din, data_w))
            narrow = keep_mask(data_w);
        else
            narrow = din & keep_mask(data_w);
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one flop of history plus an AND gate.
// Latency: rise is combinational from din, and is high for the single cycle after a 0->1 change.
// Backpressure: none; a level held high yields exactly one event.
// Ports: clk, reset (async active-high), din (level in), rise (edge pulse out).
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            din_q <= 1'b0;
        else
            din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/multi_operand_loader.sv
// Operator-paced loader: a request edge arms the unit, and each confirm edge stores one narrowed operand.
// Latency: for a confirm edge at cycle N, data_out updates at N+1, and ch_valid/ch_idx/done update at N+2.
// Backpressure: none; a confirm edge that arrives outside ARM is dropped, and the operator must press again.
// Ports: clk, reset, request, confirm, inputData in; data_out (flattened channels), ch_valid, ch_idx,
//        done, clipped, state out.
module multi_operand_loader
    import loader_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int DATA_W   = 7,
    parameter int NUM_CH   = 2,
    parameter int SAT_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     request,
    input  logic                     confirm,
    input  logic [IN_W-1:0]          inputData,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic [3:0]               ch_idx,
    output logic                     done,
    output logic                     clipped,
    output logic [2:0]               state
);

    localparam logic SAT = (SAT_MODE != 0);

    logic        req_rise;
    logic        conf_rise;
    state_t      st;
    logic        clip_pend;   // clamp flag of the operand captured in ARM, committed in CAPT
    logic        cap_en;
    logic [DATA_W-1:0] nar_dat;
    logic        nar_clip;

    edge_rise u_req_edge (
        .clk   (clk),
        .reset (reset),
        .din   (request),
        .rise  (req_rise)
    );

    edge_rise u_conf_edge (
        .clk   (clk),
        .reset (reset),
        .din   (confirm),
        .rise  (conf_rise)
    );

    assign nar_dat  = DATA_W'(narrow(MAX_W'(inputData), SAT, DATA_W));
    assign nar_clip = SAT & clips(MAX_W'(inputData), DATA_W);

    // Restart has priority: a confirm edge that coincides with a request edge captures nothing.
    assign cap_en = (st == ST_ARM) && conf_rise && !req_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= ST_IDLE;
            ch_valid  <= '0;
            ch_idx    <= 4'd0;
            done      <= 1'b0;
            clipped   <= 1'b0;
            clip_pend <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (req_rise) begin
                        st       <= ST_ARM;
                        ch_valid <= '0;
                        ch_idx   <= 4'd0;
                        clipped  <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (req_rise) begin
                        ch_valid <= '0;
                        ch_idx   <= 4'd0;
                        clipped  <= 1'b0;
                    end else if (conf_rise) begin
                        st        <= ST_CAPT;
                        clip_pend <= nar_clip;
                    end
                end
                ST_CAPT: begin
                    if (req_rise) begin
                        // The operand already written stays in data_out, but it is not marked valid.
                        st       <= ST_ARM;
                        ch_valid <= '0;
                        ch_idx   <= 4'd0;
                        clipped  <= 1'b0;
                    end else begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_idx == 4'(k))
                                ch_valid[k] <= 1'b1;
                        end
                        if (clip_pend)
                            clipped <= 1'b1;
                        if (ch_idx == 4'(NUM_CH - 1)) begin
                            st   <= ST_DONE;
                            done <= 1'b1;
                        end else begin
                            st     <= ST_ARM;
                            ch_idx <= ch_idx + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    st   <= ST_IDLE;
                    done <= 1'b0;
                end
                default: begin
                    st   <= ST_IDLE;
                    done <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

    // One enabled register per channel. Each register is written only in its own capture slot.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] op_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                op_q <= '0;
            else if (cap_en && (ch_idx == 4'(k)))
                op_q <= nar_dat;
        end

        assign data_out[k*DATA_W +: DATA_W] = op_q;
    end

endmodule
